// File: rtl/dm_pkg.sv
// Shared definitions for the data memory load/store unit: access size
// encodings, the controller state type and the misalignment rule.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_t;

    // Halfwords must sit on an even byte; words (and the reserved size,
    // which behaves as a word) must sit on a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the load/store unit: merges store data into the
// old memory word and extracts/extends load data from a memory word.
// Halfword lanes use addr_lo[1] only, words use the whole word.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;

    // Store merge: replace only the addressed lane(s), keep the rest.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Load extract: select the addressed field and sign/zero extend it.
    always_comb begin
        byte_f = old_word[{addr_lo, 3'b000} +: 8];
        half_f = old_word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: rdata = {{24{is_signed & byte_f[7]}}, byte_f};
            SZ_HALF: rdata = {{16{is_signed & half_f[15]}}, half_f};
            default: rdata = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with a load/store request/response front end for the MEM
// stage. Clears the whole array (one word per cycle) after reset, then
// serves one access per LATENCY+1 cycles at best.
// Optional feature: define DM_ALIGN_EXC_EN to flag misaligned half/word
// accesses with resp_err (no write, zero load data).
module data_mem_lsu
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LW    = $clog2(LATENCY + 1);
    localparam logic [LW-1:0] LAT_INIT = (LATENCY > 1) ? LW'(LATENCY - 2) : '0;

    logic [31:0] mem [DEPTH];

    dm_state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              access;

    logic        l_we, l_signed;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata, l_pc;

    logic        acc_we, acc_signed, acc_err;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata, acc_pc;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0] old_word, merged, ext;

    // With LATENCY=1 the access happens on the accepting edge itself, so the
    // access fields come straight from the request port while in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we     = req_we;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_pc     = req_pc;
        end else begin
            acc_we     = l_we;
            acc_size   = l_size;
            acc_signed = l_signed;
            acc_addr   = l_addr;
            acc_wdata  = l_wdata;
            acc_pc     = l_pc;
        end
    end

    assign mem_idx  = acc_addr[ADDR_W+1:2];
    assign old_word = mem[mem_idx];

`ifdef DM_ALIGN_EXC_EN
    assign acc_err = misaligned(acc_size, acc_addr[1:0]);
`else
    assign acc_err = 1'b0;
`endif

    dm_lane_align u_align (
        .old_word  (old_word),
        .wdata     (acc_wdata),
        .size      (acc_size),
        .addr_lo   (acc_addr[1:0]),
        .is_signed (acc_signed),
        .merged    (merged),
        .rdata     (ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    // Next-state logic, handshake outputs and the access strobe.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        access     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Counters, request latch and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt    <= '0;
            lat_cnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
            if (state_q == ST_IDLE && req_valid) begin
                l_we     <= req_we;
                l_size   <= req_size;
                l_signed <= req_signed;
                l_addr   <= req_addr;
                l_wdata  <= req_wdata;
                l_pc     <= req_pc;
                lat_cnt  <= LAT_INIT;
            end else if (state_q == ST_WAIT) begin
                lat_cnt <= lat_cnt - LW'(1);
            end
            if (access) begin
                resp_rdata <= (acc_we || acc_err) ? '0 : ext;
                resp_err   <= acc_err;
            end
        end
    end

    // Array writes: clear sweep, then committed stores. Nothing is written
    // while reset is asserted, so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR)
                mem[clr_cnt] <= '0;
            else if (access && acc_we && !acc_err)
                mem[mem_idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    // Store trace: one line per committed store with the post-store word.
    always_ff @(posedge clk) begin
        if (!reset && access && acc_we && !acc_err)
            $display("%0t@%h: *%h <= %h", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised data memory with a load/store front end for the pipelined CPU's MEM stage. It does word, halfword and byte accesses with a request/response handshake, a configurable access latency, and optional misalignment faults. After reset it clears the whole array by sweeping one word per cycle. It serves the same position as the single-cycle data memory, but the pipeline must stall on `req_ready`/`resp_valid`.

## Interface
- `ADDR_W`, 12, word-address bits; depth = 2^ADDR_W 32-bit words
- `LATENCY`, 1, cycles from request acceptance to `resp_valid` (≥1)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when both high at a rising edge
- `req_we`  in  1  1 store, 0 load
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- `req_signed`  in  1  load extension: 1 sign, 0 zero
- `req_addr`  in  32  byte address; word index = `req_addr[ADDR_W+1:2]`, upper bits ignored (alias)
- `req_wdata`  in  32  store data, right-aligned
- `req_pc`  in  32  PC of the issuing instruction, used for the trace only
- `resp_valid`  out  1  response held until `resp_ready`
- `resp_ready`  in  1  consumer accepts the response
- `resp_rdata`  out  32  extended load data; 0 for stores
- `resp_err`  out  1  misaligned access (see Configuration)
- `busy`  out  1  high in any state except IDLE

## Operation
- FSM states: CLEAR, IDLE, WAIT, RESP.
- **CLEAR**
  - Entered on reset.
  - A sweep counter starts at 0 and writes 0 to word `cnt` each cycle.
  - After word 2^ADDR_W−1 is written, the FSM goes to IDLE.
- **IDLE**
  - `req_ready`=1.
  - On acceptance, the request fields are latched.
  - With LATENCY=1 the FSM goes to RESP.
  - With LATENCY>1 it goes to WAIT and a counter is loaded with LATENCY−2.
- **WAIT**
  - The counter decrements each cycle.
  - At 0 the FSM goes to RESP.
- **Access**
  - Occurs on the edge that enters RESP. The store commits and the load data is registered on that edge.
- **RESP**
  - `resp_valid`=1.
  - When `resp_ready`=1 at an edge, the FSM goes to IDLE.
  - `resp_rdata` and `resp_err` stay stable while waiting.
- **Store lanes**
  - Byte: `wdata[7:0]` is written to lane `addr[1:0]`.
  - Half: `wdata[15:0]` is written to lane `addr[1]`.
  - Word: the full word is written.
  - Unaddressed bytes are preserved.
- **Load extract**
  - The same lane selection as stores.
  - Bits above the field are filled with the field MSB if `req_signed`, otherwise 0.
  - Word loads ignore `req_signed`.
- **Store trace**
  - Each committed store issues a simulation `$display`: `time@pc: *{addr[31:2],2'b00} <= merged_word`.
  - `merged_word` is the full post-store word.
- **Reset mid-operation**
  - Any in-flight request is abandoned. An uncommitted store is never written.
  - CLEAR restarts at word 0.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=1.
- **Clear duration:** `req_ready` rises exactly 2^ADDR_W cycles after the cycle where reset is deasserted.
- **Latency:** accept at edge E → `resp_valid` is high in the cycle after edge E+LATENCY−1.
  - LATENCY=1 gives the response in the next cycle.
- **Throughput:** one request per LATENCY+1 cycles at best; `req_ready`=0 in WAIT and RESP.
- **Ordering:** a load following a store to the same word returns the merged value, with no hazard window.
- **`resp_ready` early:** `resp_ready` high before `resp_valid` has no effect.

## Configuration
- Macro: `DM_ALIGN_EXC_EN`.
- **Defined:**
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, is misaligned.
  - A misaligned access completes with normal timing and `resp_err`=1.
  - A misaligned store makes no memory write and no trace line.
  - A misaligned load returns `resp_rdata`=0.
- **Undefined:**
  - `resp_err` is tied to 0.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.

## Structure
- **Package `dm_pkg`:**
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum `dm_state_t`.
  - Misalignment function.
- **Sub-module `dm_lane_align`:**
  - Combinational.
  - Produces the store merge (old word, wdata, size, addr[1:0] → new word).
  - Produces the load extract/extend (word, size, signed, addr[1:0] → rdata).
- The top level holds the FSM, the counters and the array.

## Test plan
- Reset, ADDR_W=4 → `req_ready` stays 0 for exactly 16 cycles, then rises; all words read 0.
- Word store 0x12345678 @0x8, then byte store 0xAB @0xB → word load @0x8 returns 0xAB345678. The trace shows both merged words.
- Word 0x0000F080 @0x0: signed byte load @0x0 → 0xFFFFFF80; unsigned byte load @0x0 → 0x00000080; signed half load @0x0 → 0xFFFFF080.
- LATENCY=3, `resp_ready` held low for 5 cycles:
  - `resp_valid` rises in the 3rd cycle after acceptance and holds with stable data.
  - `req_ready` stays low until the cycle after the `resp_ready` handshake.
- Store in WAIT, then reset asserted → the word is unchanged after CLEAR completes (reads 0), and there is no trace line.
- With `DM_ALIGN_EXC_EN`: half store @0x5 → `resp_err`=1 and memory unchanged. Without the macro: the same store writes lane 0 of word 1.
